// File: rtl/in_driver.sv
// 16-bit memory-mapped input port: sync, per-bit debounce, edge flags, irq, registered bus reads.
// Define IN_DRIVER_DEBOUNCE_EN to build the per-bit debounce counters; otherwise stable follows sync2.
module in_driver #(
  parameter logic [31:0] DATA_ADDR       = 32'd12,
  parameter logic [31:0] FLAG_ADDR       = 32'd16,
  parameter logic [31:0] CFG_ADDR        = 32'd20,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IO_pins,
  input  logic [31:0] adress,
  input  logic [31:0] bus_in,
  input  logic        we,
  output logic [31:0] bus_out,
  output logic        irq
);

  logic [15:0] sync1, sync2, stable, stable_next;
  logic [15:0] flags, flags_next, flag_clr, rise, fall;
  logic [31:0] cfg, rd_data;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef IN_DRIVER_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt      [16];
  logic [CW-1:0] cnt_next [16];

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_next = stable;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_next[i] = sync2[i];
        else                    cnt_next[i]    = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 16; i++) begin
      if (reset) cnt[i] <= '0;
      else       cnt[i] <= cnt_next[i];
    end
  end
`else
  always_comb stable_next = sync2;
`endif

  // Set has priority over a same-cycle write-1-to-clear.
  always_comb begin
    rise       = stable_next & ~stable;
    fall       = ~stable_next & stable;
    flag_clr   = (we && adress == FLAG_ADDR) ? bus_in[15:0] : '0;
    flags_next = (flags & ~flag_clr) | (rise & cfg[15:0]) | (fall & cfg[31:16]);
  end

  always_comb begin
    rd_data = '0;
    if (adress == DATA_ADDR)      rd_data = {16'b0, stable};
    else if (adress == FLAG_ADDR) rd_data = {16'b0, flags};
    else if (adress == CFG_ADDR)  rd_data = cfg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      flags   <= '0;
      cfg     <= '0;
      bus_out <= '0;
    end else begin
      sync1   <= IO_pins;
      sync2   <= sync1;
      stable  <= stable_next;
      flags   <= flags_next;
      bus_out <= rd_data;
      if (we && adress == CFG_ADDR) cfg <= bus_in;
    end
  end

  assign irq = |flags;

endmodule

// File: tb/tb_in_driver.sv
// Directed bench for in_driver; latency expectations follow whether IN_DRIVER_DEBOUNCE_EN is defined.
module tb_in_driver;

  localparam logic [31:0] DATA_ADDR = 32'd12;
  localparam logic [31:0] FLAG_ADDR = 32'd16;
  localparam logic [31:0] CFG_ADDR  = 32'd20;
`ifdef IN_DRIVER_DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IO_pins;
  logic [31:0] adress, bus_in, bus_out;
  logic        we, irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rv;

  in_driver #(
    .DATA_ADDR(DATA_ADDR),
    .FLAG_ADDR(FLAG_ADDR),
    .CFG_ADDR(CFG_ADDR),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .IO_pins(IO_pins),
    .adress(adress),
    .bus_in(bus_in),
    .we(we),
    .bus_out(bus_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    repeat (DB + 4) tick;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adress = a;
    bus_in = d;
    we     = 1'b1;
    tick;
    we     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    adress = a;
    we     = 1'b0;
    tick;
    d = bus_out;
  endtask

  // Pulse one pin for len sampled cycles and watch the DATA register bit.
  task automatic pulse(input int unsigned b, input int unsigned len);
    int          first;
    int unsigned seen, exp_seen;
    first  = -1;
    seen   = 0;
    adress = DATA_ADDR;
    we     = 1'b0;
    IO_pins[b] = 1'b1;
    for (int unsigned e = 0; e < len + DB + 6; e++) begin
      tick;
      if (bus_out[b]) begin
        seen++;
        if (first < 0) first = int'(e);
      end
      if (e == len - 1) IO_pins[b] = 1'b0;
    end
    exp_seen = (len >= DB) ? len : 0;
    check("pulse_width", seen, exp_seen);
    if (exp_seen != 0) check("pulse_latency", first, DB + 2);
  endtask

  initial begin
    reset   = 1'b1;
    IO_pins = 16'hFFFF;
    adress  = DATA_ADDR;
    bus_in  = '0;
    we      = 1'b0;
    repeat (3) tick;
    check("reset_bus_out", bus_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    reset = 1'b0;
    for (int unsigned e = 0; e < DB + 4; e++) begin
      tick;
      check("post_reset_data", bus_out, (e >= DB + 2) ? 32'h0000_FFFF : 32'h0);
    end
    rd(FLAG_ADDR, rv); check("reset_flags", rv, 32'h0);
    rd(CFG_ADDR, rv);  check("reset_cfg", rv, 32'h0);

    IO_pins = 16'h0000;
    settle;
    rd(DATA_ADDR, rv); check("pins_low", rv, 32'h0);
    rd(FLAG_ADDR, rv); check("fall_no_cfg", rv, 32'h0);

    // Edge flags: rise on bit1, fall on bit0.
    wr(CFG_ADDR, 32'h0001_0002);
    IO_pins[0] = 1'b1; settle;
    rd(FLAG_ADDR, rv); check("rise0_masked", rv, 32'h0);
    IO_pins[1] = 1'b1; settle;
    rd(FLAG_ADDR, rv); check("rise1_flag", rv, 32'h0002);
    check("rise1_irq", {31'b0, irq}, 32'h1);
    IO_pins[0] = 1'b0; settle;
    rd(FLAG_ADDR, rv); check("fall0_flag", rv, 32'h0003);
    IO_pins[1] = 1'b0; settle;
    rd(FLAG_ADDR, rv); check("fall1_masked", rv, 32'h0003);
    rd(CFG_ADDR, rv);  check("cfg_readback", rv, 32'h0001_0002);

    // Write-1-to-clear.
    wr(FLAG_ADDR, 32'h1);
    check("w1c0_irq", {31'b0, irq}, 32'h1);
    rd(FLAG_ADDR, rv); check("w1c0_flags", rv, 32'h0002);
    wr(FLAG_ADDR, 32'h2);
    check("w1c1_irq", {31'b0, irq}, 32'h0);
    rd(FLAG_ADDR, rv); check("w1c1_flags", rv, 32'h0);

    // Set flag0, then clear bits 0 and 1 on the cycle bit1's rise is accepted.
    IO_pins[0] = 1'b1; settle;
    IO_pins[0] = 1'b0; settle;
    rd(FLAG_ADDR, rv); check("pre_simul", rv, 32'h0001);
    IO_pins[1] = 1'b1;
    repeat (DB + 1) tick;
    adress = FLAG_ADDR;
    bus_in = 32'h3;
    we     = 1'b1;
    tick;
    we     = 1'b0;
    check("same_cycle_read", bus_out, 32'h0001);
    rd(FLAG_ADDR, rv); check("set_wins", rv, 32'h0002);

    wr(CFG_ADDR, 32'h0);
    rd(FLAG_ADDR, rv); check("cfg_no_alter", rv, 32'h0002);
    wr(DATA_ADDR, 32'h0);
    rd(DATA_ADDR, rv); check("data_ro", rv, 32'h0002);
    adress = FLAG_ADDR; bus_in = 32'hFFFF_FFFF; we = 1'b0;
    tick;
    rd(FLAG_ADDR, rv); check("we_low_ignored", rv, 32'h0002);
    rd(32'h24, rv);    check("unmapped", rv, 32'h0);

    wr(FLAG_ADDR, 32'hFFFF);
    IO_pins = 16'h0000; settle;
    wr(CFG_ADDR, 32'h0000_0088);

    // Glitch, clean pulse and single-cycle pulse.
    pulse(3, 3);
    rd(FLAG_ADDR, rv); check("glitch_flag", rv, (3 >= DB) ? 32'h0008 : 32'h0);
    wr(FLAG_ADDR, 32'hFFFF);
    pulse(3, 4);
    rd(FLAG_ADDR, rv); check("pulse4_flag", rv, 32'h0008);
    wr(FLAG_ADDR, 32'hFFFF);
    pulse(7, 1);
    rd(FLAG_ADDR, rv); check("pulse1_flag", rv, (1 >= DB) ? 32'h0080 : 32'h0);

    // Reset with flags set and pins held high.
    wr(CFG_ADDR, 32'hFFFF_FFFF);
    IO_pins = 16'hFFFF; settle;
    rd(FLAG_ADDR, rv); check("all_rise", rv, 32'hFFFF);
    reset  = 1'b1;
    adress = CFG_ADDR;
    repeat (2) tick;
    check("reset2_bus_out", bus_out, 32'h0);
    check("reset2_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    rd(CFG_ADDR, rv);  check("reset2_cfg", rv, 32'h0);
    settle;
    rd(FLAG_ADDR, rv); check("redebounce_no_flag", rv, 32'h0);
    rd(DATA_ADDR, rv); check("redebounce_data", rv, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
